// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: PC sequencer, single-outstanding request/grant/response
// memory port and a DEPTH-entry prefetch FIFO of {pc, instruction} pairs.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  output logic                     MEM_REQ,
  output logic [XLEN-1:0]          MEM_ADDR,
  input  logic                     MEM_GNT,
  input  logic                     MEM_RVALID,
  input  logic [ILEN-1:0]          MEM_RDATA,
  output logic                     INSTR_VALID,
  output logic [ILEN-1:0]          INSTR,
  output logic [XLEN-1:0]          INSTR_PC,
  input  logic                     INSTR_READY,
  input  logic                     REDIRECT,
  input  logic [XLEN-1:0]          REDIRECT_PC,
  output logic [$clog2(DEPTH):0]   BUF_COUNT
);

  localparam int unsigned     PW         = $clog2(DEPTH);
  localparam logic [PW:0]     FULL       = (PW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(ILEN / 8);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] req_pc, req_pc_nxt;
  logic [ILEN-1:0] buf_instr [DEPTH];
  logic [XLEN-1:0] buf_pc    [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count, count_nxt;
  logic            grant;
  logic            push;
  logic            pop;

  assign INSTR_VALID = (count != '0);
  assign INSTR       = INSTR_VALID ? buf_instr[rd_ptr] : '0;
  assign INSTR_PC    = INSTR_VALID ? buf_pc[rd_ptr]    : '0;
  assign MEM_ADDR    = fetch_pc;
  assign BUF_COUNT   = count;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    push         = 1'b0;
    MEM_REQ      = (state == S_REQ) && (count < FULL) && !REDIRECT && !RST;
    grant        = MEM_REQ && MEM_GNT;
    pop          = INSTR_VALID && INSTR_READY && !REDIRECT;

    if (REDIRECT) begin
      // An in-flight request cannot be cancelled; its response must still be absorbed.
      fetch_pc_nxt = REDIRECT_PC & ALIGN_MASK;
      case (state)
        S_WAIT:  state_nxt = MEM_RVALID ? S_REQ : S_DROP;
        S_DROP:  state_nxt = MEM_RVALID ? S_REQ : S_DROP;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (grant) begin
            req_pc_nxt   = fetch_pc;
            fetch_pc_nxt = fetch_pc + PC_STEP;
            state_nxt    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (MEM_RVALID) begin
            push      = 1'b1;
            state_nxt = S_REQ;
          end
        end
        S_DROP: begin
          if (MEM_RVALID) state_nxt = S_REQ;
        end
        default: state_nxt = S_REQ;
      endcase
    end

    if (REDIRECT) count_nxt = '0;
    else          count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      count    <= count_nxt;
      if (REDIRECT) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (push) begin
      buf_instr[wr_ptr] <= MEM_RDATA;
      buf_pc[wr_ptr]    <= req_pc;
    end
  end

endmodule
